// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: single-port RAM plus an I/O window holding
// a TX FIFO towards the host link, an RX FIFO from it, and a sticky overflow flag.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a_in,
  input  logic [7:0]  mem_d_in,
  input  logic        mem_wr_in,
  output logic [7:0]  mem_d_out,
  output logic        io_buffer_full_out,
  output logic [7:0]  tx_d_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [7:0]  rx_d_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG:0];

  logic                      io_sel, data_sel, status_sel;
  logic [2:0]                io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                ram [2**RAM_ADDR_WIDTH];
  logic [7:0]                rd_next;
  logic                      ovf;
  logic                      unused_addr;

  logic [7:0]                tx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   tx_count, tx_free;
  logic                      tx_full, tx_push, tx_pop, tx_accept;

  logic [7:0]                rx_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   rx_count;
  logic                      rx_full, rx_nonempty, rx_push, rx_pop;

  assign io_sel      = (mem_a_in[17:16] == 2'b11);
  assign io_off      = mem_a_in[2:0];
  assign data_sel    = io_sel && (io_off == 3'd0);
  assign status_sel  = io_sel && (io_off == 3'd4);
  assign ram_addr    = mem_a_in[RAM_ADDR_WIDTH-1:0];
  assign unused_addr = ^mem_a_in[31:18];

  // RAM: contents deliberately not reset
  always_ff @(posedge clk_in) begin
    if (mem_wr_in && !io_sel) ram[ram_addr] <= mem_d_in;
  end

  always_comb begin
    rd_next = 8'h00;
    if (!mem_wr_in) begin
      if (!io_sel)
        rd_next = ram[ram_addr];
      else if (io_off == 3'd0)
        rd_next = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
      else if (io_off == 3'd4)
        rd_next = {5'b0, ovf, rx_nonempty, tx_full};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) mem_d_out <= 8'h00;
    else        mem_d_out <= rd_next;
  end

  // TX FIFO: a push into a full FIFO survives only if the head leaves the same cycle
  assign tx_full            = (tx_count == DEPTH_CNT);
  assign tx_free            = DEPTH_CNT - tx_count;
  assign tx_valid_out       = (tx_count != '0);
  assign tx_d_out           = tx_valid_out ? tx_mem[tx_rd_ptr] : 8'h00;
  assign io_buffer_full_out = (int'(tx_free) <= FULL_MARGIN);
  assign tx_push            = mem_wr_in && data_sel;
  assign tx_pop             = tx_valid_out && tx_ready_in;
  assign tx_accept          = tx_push && (!tx_full || tx_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (tx_accept) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)    tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_accept, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
      if (tx_push && !tx_accept)         ovf <= 1'b1;
      else if (mem_wr_in && status_sel)  ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_accept) tx_mem[tx_wr_ptr] <= mem_d_in;
  end

  // RX FIFO: bus reads see only entries stored before this cycle
  assign rx_full      = (rx_count == DEPTH_CNT);
  assign rx_nonempty  = (rx_count != '0);
  assign rx_ready_out = !rx_full;
  assign rx_push      = rx_valid_in && rx_ready_out;
  assign rx_pop       = !mem_wr_in && data_sel && rx_nonempty;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_d_in;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the byte-wide CPU memory bus (address, write data, write strobe, 1-cycle-latency read data) driven by the allocator. Serves a single-port byte RAM and a small memory-mapped I/O window. Behind the I/O window sit a TX byte FIFO towards the host link and an RX byte FIFO from it. Provides io_buffer_full_out backpressure to the core.

Parameters:
RAM_ADDR_WIDTH, 17, RAM byte-address bits; RAM size 2^RAM_ADDR_WIDTH bytes.
FIFO_DEPTH_LOG, 3, log2 of TX and RX FIFO depth (default 8 entries each).
FULL_MARGIN, 2, io_buffer_full_out asserts when TX free entries <= FULL_MARGIN.

Ports:
clk_in  input  1  clock; all state on rising edge.
rst_in  input  1  reset; asynchronous, active-high.
mem_a_in  input  32  byte address from allocator.
mem_d_in  input  8  write data.
mem_wr_in  input  1  1 = write cycle, 0 = read cycle.
mem_d_out  output  8  read data; valid the cycle after the address.
io_buffer_full_out  output  1  TX FIFO nearly full.
tx_d_out  output  8  TX FIFO head byte.
tx_valid_out  output  1  TX FIFO non-empty.
tx_ready_in  input  1  host consumes head when tx_valid_out && tx_ready_in.
rx_d_in  input  8  incoming host byte.
rx_valid_in  input  1  incoming byte valid.
rx_ready_out  output  1  RX FIFO not full.

Behaviour:
- Decode: io_sel = (mem_a_in[17:16] == 2'b11); otherwise RAM at mem_a_in[RAM_ADDR_WIDTH-1:0].
- Upper RAM address bits are ignored (alias).
- Every cycle is a transaction; idle is address 0, mem_wr_in=0: a harmless RAM read with no side effects.
- RAM write: byte stored at the posedge where mem_wr_in=1.
- RAM read: mem_d_out is registered and equals RAM[addr of previous cycle]. A read immediately after a write to the same address returns the new byte.
- RAM contents are not reset.
- After a write cycle, mem_d_out = 0x00 the next cycle.
- I/O offset mem_a_in[2:0]=0, DATA register:
  - Write pushes mem_d_in into the TX FIFO.
  - Read pops the RX head; mem_d_out = head next cycle.
  - Read with RX empty returns 0x00 and does not pop.
- I/O offset 4, STATUS register:
  - Read returns {5'b0, ovf, rx_nonempty, tx_full}.
  - Write of any data clears ovf.
- Other I/O offsets: reads return 0x00; writes are ignored.
- TX FIFO:
  - Push when the bus writes DATA.
  - Pop when tx_valid_out && tx_ready_in.
  - tx_d_out = head entry; tx_valid_out = (count != 0).
  - Both combinational from registered state.
- TX full plus push:
  - Without a same-cycle pop: byte dropped, sticky ovf <= 1.
  - With a same-cycle pop: push accepted, count unchanged.
- TX empty plus push: tx_valid_out goes high the next cycle. No bypass, so a same-cycle pop is impossible.
- RX FIFO:
  - Push when rx_valid_in && rx_ready_out; rx_ready_out = !rx_full.
  - RX full plus bus pop plus rx_valid_in: pop happens; the push is not accepted because rx_ready_out was 0.
  - RX empty: no pop; a same-cycle incoming push is not visible to that read.
- Pointers wrap modulo 2^FIFO_DEPTH_LOG. Count width is FIFO_DEPTH_LOG+1.
- io_buffer_full_out = ((2^FIFO_DEPTH_LOG - tx_count) <= FULL_MARGIN), combinational from count.
- ovf priority: a clearing STATUS write and a new overflow in the same cycle cannot occur (single bus op per cycle).
- Reset values:
  - mem_d_out=0, tx_valid_out=0, tx_d_out=0, io_buffer_full_out=0, rx_ready_out=1.
  - FIFOs empty, ovf=0.
- Reset mid-operation:
  - In-flight read data is lost; mem_d_out forced to 0.
  - FIFO contents are discarded.

Test Plan:
- RAM write then read: write 0xA5 to 0x00100, next cycle read 0x00100 -> mem_d_out=0xA5 the cycle after; read 0x20100 (alias) -> 0xA5.
- Back-to-back reads: read 0x10,0x11,0x12,0x13 holding 0x11,0x22,0x33,0x44 -> mem_d_out 0x11,0x22,0x33,0x44 on consecutive cycles, each one cycle later.
- TX path: tx_ready_in=0, write 0x30000 with 0x41..0x48 (8 bytes):
  - io_buffer_full_out rises after the 6th push; STATUS reads 0x01 (tx_full).
  - A 9th write sets ovf; STATUS reads 0x05.
  - Raise tx_ready_in -> tx_d_out streams 0x41..0x48 in order, then tx_valid_out=0.
- Full TX with simultaneous push and pop: 8 entries, tx_ready_in=1 plus write 0x99 -> count stays 8, ovf stays 0, 0x99 emerges last.
- RX path:
  - Push 0x10,0x20 via rx_valid_in; read 0x30004 -> 0x02; read 0x30000 twice -> 0x10, 0x20.
  - A third read -> 0x00; STATUS -> 0x00.
  - Fill RX to 8 -> rx_ready_out=0.
- Async reset: assert rst_in mid-TX-stream between clock edges -> tx_valid_out, mem_d_out, io_buffer_full_out drop to 0 immediately, rx_ready_out=1; RAM byte at 0x00100 retains 0xA5 after reset.
